ras_ckpt: RTL and testbench

Parametrised return-address stack for the fetch stage, generalised in data width and depth. Adds an occupancy counter with overflow/underflow flags, and a per-prediction checkpoint (pointer, count, top-entry data) kept in the branch-order buffer. On a backend flush the checkpoint is restored: pointer, count and the top entry are rewritten, repairing a slot clobbered by a wrong-path push. The block sits between the BTB/branch decoder (op source) and the next-PC mux (consumes top_o).

---
 rtl/ras_ckpt.sv | 111 +++++++++++
 tb/tb_ras_ckpt.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ckpt.sv
// Return-address stack with occupancy tracking and branch-order-buffer checkpoint restore.
// Restore rewrites pointer, count and the checkpointed top entry, repairing wrong-path clobbers.
module ras_ckpt #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PW    = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          stall_i,
  input  logic [1:0]    op_i,
  input  logic [DW-1:0] push_dat_i,
  input  logic          rst_vld_i,
  input  logic [PW-1:0] rst_ptr_i,
  input  logic [PW:0]   rst_cnt_i,
  input  logic [DW-1:0] rst_top_i,
  output logic [DW-1:0] top_o,
  output logic [PW-1:0] ckpt_ptr_o,
  output logic [PW:0]   ckpt_cnt_o,
  output logic [DW-1:0] ckpt_top_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          ovf_o,
  output logic          udf_o
);

  localparam logic [1:0]  OpNoop    = 2'b00;
  localparam logic [1:0]  OpPush    = 2'b01;
  localparam logic [1:0]  OpPop     = 2'b10;
  localparam logic [1:0]  OpPopPush = 2'b11;
  localparam logic [PW:0] CntMax    = (PW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          we;
  logic [PW-1:0] widx;
  logic [DW-1:0] wdat;
  logic          is_full, is_empty;

  assign is_full  = (cnt_q == CntMax);
  assign is_empty = (cnt_q == '0);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    udf_d = 1'b0;
    we    = 1'b0;
    widx  = ptr_q;
    wdat  = push_dat_i;
    if (rst_vld_i) begin
      // Restore wins over any same-cycle op; an out-of-range count is clamped.
      ptr_d = rst_ptr_i;
      cnt_d = (rst_cnt_i > CntMax) ? CntMax : rst_cnt_i;
      we    = 1'b1;
      widx  = rst_ptr_i;
      wdat  = rst_top_i;
    end else if (!stall_i) begin
      unique case (op_i)
        OpNoop: ;
        OpPush: begin
          ptr_d = ptr_q + PW'(1);
          widx  = ptr_q + PW'(1);
          we    = 1'b1;
          cnt_d = is_full ? cnt_q : cnt_q + (PW+1)'(1);
          ovf_d = is_full;
        end
        OpPop: begin
          ptr_d = ptr_q - PW'(1);
          cnt_d = is_empty ? cnt_q : cnt_q - (PW+1)'(1);
          udf_d = is_empty;
        end
        OpPopPush: begin
          we    = 1'b1;
          cnt_d = is_empty ? (PW+1)'(1) : cnt_q;
          udf_d = is_empty;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (we) mem_q[widx] <= wdat;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign top_o      = mem_q[ptr_q];
  assign ckpt_top_o = mem_q[ptr_q];
  assign ckpt_ptr_o = ptr_q;
  assign ckpt_cnt_o = cnt_q;
  assign empty_o    = is_empty;
  assign full_o     = is_full;
  assign ovf_o      = ovf_q;
  assign udf_o      = udf_q;

endmodule

// File: tb/tb_ras_ckpt.sv
// Bench for ras_ckpt: directed scenarios plus random ops against an array-based stack model.
module tb_ras_ckpt;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int PW    = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          stall_i = 1'b0;
  logic [1:0]    op_i = 2'b00;
  logic [DW-1:0] push_dat_i = '0;
  logic          rst_vld_i = 1'b0;
  logic [PW-1:0] rst_ptr_i = '0;
  logic [PW:0]   rst_cnt_i = '0;
  logic [DW-1:0] rst_top_i = '0;
  logic [DW-1:0] top_o, ckpt_top_o;
  logic [PW-1:0] ckpt_ptr_o;
  logic [PW:0]   ckpt_cnt_o;
  logic          empty_o, full_o, ovf_o, udf_o;

  ras_ckpt #(.DW(DW), .DEPTH(DEPTH), .PW(PW)) dut (
    .clock(clock), .reset_n(reset_n), .stall_i(stall_i), .op_i(op_i),
    .push_dat_i(push_dat_i), .rst_vld_i(rst_vld_i), .rst_ptr_i(rst_ptr_i),
    .rst_cnt_i(rst_cnt_i), .rst_top_i(rst_top_i), .top_o(top_o),
    .ckpt_ptr_o(ckpt_ptr_o), .ckpt_cnt_o(ckpt_cnt_o), .ckpt_top_o(ckpt_top_o),
    .empty_o(empty_o), .full_o(full_o), .ovf_o(ovf_o), .udf_o(udf_o)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference stack: plain array, integer pointer/count, modulo arithmetic.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_ptr, m_cnt;
  bit            m_ovf, m_udf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_ptr = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic model_apply(input bit st, input logic [1:0] op, input logic [DW-1:0] dat,
                             input bit rv, input int rp, input int rc, input logic [DW-1:0] rt);
    m_ovf = 0;
    m_udf = 0;
    if (rv) begin
      m_ptr = rp;
      m_cnt = (rc > DEPTH) ? DEPTH : rc;
      m_mem[rp] = rt;
    end else if (!st) begin
      case (op)
        2'b01: begin
          m_ovf = (m_cnt == DEPTH);
          m_ptr = (m_ptr + 1) % DEPTH;
          m_mem[m_ptr] = dat;
          if (m_cnt < DEPTH) m_cnt++;
        end
        2'b10: begin
          m_udf = (m_cnt == 0);
          m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
          if (m_cnt > 0) m_cnt--;
        end
        2'b11: begin
          m_udf = (m_cnt == 0);
          m_mem[m_ptr] = dat;
          if (m_cnt == 0) m_cnt = 1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".top"},   top_o,      m_mem[m_ptr]);
    check({tag, ".ctop"},  ckpt_top_o, m_mem[m_ptr]);
    check({tag, ".ptr"},   64'(ckpt_ptr_o), 64'(m_ptr));
    check({tag, ".cnt"},   64'(ckpt_cnt_o), 64'(m_cnt));
    check({tag, ".empty"}, 64'(empty_o), 64'(m_cnt == 0));
    check({tag, ".full"},  64'(full_o),  64'(m_cnt == DEPTH));
    check({tag, ".ovf"},   64'(ovf_o),   64'(m_ovf));
    check({tag, ".udf"},   64'(udf_o),   64'(m_udf));
  endtask

  // One clock: drive, clock, update the model, compare just after the edge.
  task automatic step(input string tag, input bit st, input logic [1:0] op,
                      input logic [DW-1:0] dat, input bit rv, input int rp, input int rc,
                      input logic [DW-1:0] rt);
    stall_i = st; op_i = op; push_dat_i = dat;
    rst_vld_i = rv; rst_ptr_i = PW'(rp); rst_cnt_i = (PW+1)'(rc); rst_top_i = rt;
    @(posedge clock);
    model_apply(st, op, dat, rv, rp, rc, rt);
    #1;
    check_model(tag);
  endtask

  task automatic push(input logic [DW-1:0] d);
    step("push", 0, 2'b01, d, 0, 0, 0, '0);
  endtask
  task automatic pop();
    step("pop", 0, 2'b10, '0, 0, 0, 0, '0);
  endtask
  task automatic idle();
    step("noop", 0, 2'b00, '0, 0, 0, 0, '0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 0;
    stall_i = 0; op_i = 2'b00; rst_vld_i = 0;
    #1;
    model_reset();
    check_model("reset");
    @(negedge clock);
    reset_n = 1;
  endtask

  initial begin
    model_reset();
    #12;
    check_model("por");
    check("por.top_const", top_o, 64'h0);
    check("por.empty_const", 64'(empty_o), 64'h1);
    @(negedge clock);
    reset_n = 1;

    // Basic push/pop.
    push(64'h1000); push(64'h2000); push(64'h3000);
    check("t1.top3000", top_o, 64'h3000);
    check("t1.cnt3", 64'(ckpt_cnt_o), 64'd3);
    pop(); pop();
    check("t1.top1000", top_o, 64'h1000);
    check("t1.cnt1", 64'(ckpt_cnt_o), 64'd1);

    // Overflow wrap.
    do_reset();
    for (int i = 1; i <= 16; i++) push(64'(i));
    check("t2.full", 64'(full_o), 64'h1);
    check("t2.noovf", 64'(ovf_o), 64'h0);
    push(64'd17);
    check("t2.ovf", 64'(ovf_o), 64'h1);
    check("t2.ptr1", 64'(ckpt_ptr_o), 64'd1);
    check("t2.top17", top_o, 64'd17);
    idle();
    check("t2.ovf_once", 64'(ovf_o), 64'h0);

    // Underflow from reset.
    do_reset();
    pop();
    check("t3.udf", 64'(udf_o), 64'h1);
    check("t3.ptr15", 64'(ckpt_ptr_o), 64'd15);
    idle();
    check("t3.udf_once", 64'(udf_o), 64'h0);

    // Checkpoint repair after wrong-path clobber.
    do_reset();
    push(64'hA0);
    pop();
    push(64'hBB);
    check("t4.clobber", top_o, 64'hBB);
    step("t4.restore", 0, 2'b00, '0, 1, 1, 1, 64'hA0);
    check("t4.topA0", top_o, 64'hA0);

    // Restore beats push; stall blocks push.
    push(64'h11);
    step("t5.rst_push", 0, 2'b01, 64'hFF, 1, 1, 1, 64'hA0);
    check("t5.noovf", 64'(ovf_o), 64'h0);
    check("t5.topA0", top_o, 64'hA0);
    step("t5.stall", 1, 2'b01, 64'hEE, 0, 0, 0, '0);
    check("t5.cnt1", 64'(ckpt_cnt_o), 64'd1);
    step("t5.clamp", 0, 2'b10, '0, 1, 3, 31, 64'h77);
    check("t5.clamp16", 64'(ckpt_cnt_o), 64'd16);

    // POPPUSH then async reset mid-sequence.
    do_reset();
    push(64'h33); push(64'h44);
    step("t6.poppush", 0, 2'b11, 64'h55, 0, 0, 0, '0);
    check("t6.top55", top_o, 64'h55);
    check("t6.ptr2", 64'(ckpt_ptr_o), 64'd2);
    op_i = 2'b01; push_dat_i = 64'h99;
    #3;
    reset_n = 0;
    #1;
    model_reset();
    check_model("t6.async");
    @(posedge clock);
    #1;
    check_model("t6.held");
    op_i = 2'b00;
    @(negedge clock);
    reset_n = 1;
    step("t6.pp_empty", 0, 2'b11, 64'h66, 0, 0, 0, '0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      bit            st, rv;
      logic [1:0]    op;
      logic [DW-1:0] d, t;
      st = ($urandom_range(7) == 0);
      rv = ($urandom_range(9) == 0);
      op = 2'($urandom);
      d  = {$urandom, $urandom};
      t  = {$urandom, $urandom};
      step("rand", st, op, d, rv, int'($urandom_range(DEPTH - 1)), int'($urandom_range(31)), t);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
